// File: rtl/otp_auth_ctrl.sv
`timescale 1ns/1ps
// OTP session controller: fetches a reference OTP, collects four BCD digits, compares on enter, counts failures.
// Latency: every output is registered, one cycle after the causing edge; no backpressure, gen_req holds until gen_ack.
module otp_auth_ctrl #(
    parameter int EXPIRE_CYC = 50_000_000,
    parameter int MAX_ATT    = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        digit_vld,
    input  logic [3:0]  digit,
    input  logic        enter,
    input  logic        clear,
    output logic        gen_req,
    input  logic        gen_ack,
    input  logic [15:0] lfsr_otp,
    output logic [15:0] otp_ref,
    output logic [15:0] user_otp,
    output logic        unlock,
    output logic        lock,
    output logic        expire,
    output logic [1:0]  wrng_att,
    output logic        busy
);
    localparam int            TW         = $clog2(EXPIRE_CYC);
    localparam logic [TW-1:0] TIMER_LAST = TW'(EXPIRE_CYC - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [1:0]    ATT_LOCK   = 2'(MAX_ATT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ENTRY,
        S_CHECK,
        S_UNLOCKED,
        S_LOCKED,
        S_EXPIRED
    } state_t;

    state_t         state, state_nx;
    logic [TW-1:0]  timer, timer_nx;
    logic [2:0]     cnt, cnt_nx;
    logic [15:0]    otp_ref_nx, user_otp_nx;
    logic           unlock_nx, lock_nx, expire_nx, gen_req_nx, busy_nx;
    logic [1:0]     wrng_att_nx, att_inc;

    assign att_inc = wrng_att + 2'd1;

    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        cnt_nx      = cnt;
        otp_ref_nx  = otp_ref;
        user_otp_nx = user_otp;
        unlock_nx   = unlock;
        lock_nx     = lock;
        expire_nx   = expire;
        wrng_att_nx = wrng_att;

        case (state)
            S_IDLE: begin
                if (start) state_nx = S_REQ;
            end
            S_REQ: begin
                if (gen_ack) begin
                    otp_ref_nx  = lfsr_otp;
                    user_otp_nx = '0;
                    cnt_nx      = '0;
                    timer_nx    = '0;
                    state_nx    = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (timer == TIMER_LAST) begin
                    state_nx  = S_EXPIRED;
                    expire_nx = 1'b1;
                end else begin
                    timer_nx = timer + TIMER_ONE;
                    if (clear) begin
                        user_otp_nx = '0;
                        cnt_nx      = '0;
                    end else if (enter && cnt == 3'd4) begin
                        state_nx = S_CHECK;
                    end else if (digit_vld && digit <= 4'd9 && cnt < 3'd4) begin
                        user_otp_nx = {user_otp[11:0], digit};
                        cnt_nx      = cnt + 3'd1;
                    end
                end
            end
            S_CHECK: begin
                // The session clock keeps running through the compare cycle so expiry stays wall-clock exact.
                if (timer != TIMER_LAST) timer_nx = timer + TIMER_ONE;
                if (user_otp == otp_ref) begin
                    state_nx  = S_UNLOCKED;
                    unlock_nx = 1'b1;
                end else begin
                    wrng_att_nx = att_inc;
                    if (att_inc == ATT_LOCK) begin
                        state_nx = S_LOCKED;
                        lock_nx  = 1'b1;
                    end else if (timer == TIMER_LAST) begin
                        state_nx  = S_EXPIRED;
                        expire_nx = 1'b1;
                    end else begin
                        state_nx    = S_ENTRY;
                        user_otp_nx = '0;
                        cnt_nx      = '0;
                    end
                end
            end
            S_UNLOCKED, S_EXPIRED: begin
                if (start) begin
                    unlock_nx   = 1'b0;
                    expire_nx   = 1'b0;
                    wrng_att_nx = '0;
                    state_nx    = S_REQ;
                end
            end
            S_LOCKED: begin
                state_nx = S_LOCKED;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        gen_req_nx = (state_nx == S_REQ);
        busy_nx    = (state_nx == S_REQ) || (state_nx == S_ENTRY) || (state_nx == S_CHECK);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            timer    <= '0;
            cnt      <= '0;
            otp_ref  <= '0;
            user_otp <= '0;
            unlock   <= 1'b0;
            lock     <= 1'b0;
            expire   <= 1'b0;
            wrng_att <= '0;
            gen_req  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            cnt      <= cnt_nx;
            otp_ref  <= otp_ref_nx;
            user_otp <= user_otp_nx;
            unlock   <= unlock_nx;
            lock     <= lock_nx;
            expire   <= expire_nx;
            wrng_att <= wrng_att_nx;
            gen_req  <= gen_req_nx;
            busy     <= busy_nx;
        end
    end

endmodule

// File: tb/tb_otp_auth_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench: a session-level reference model predicts every output change with its cycle stamp;
// a negedge monitor compares each observed change (and requested probes) against the predictions.
module tb_otp_auth_ctrl;
    localparam int EXP  = 100;
    localparam int MAXA = 3;
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_ENTRY = 2, PH_CHECK = 3,
                   PH_UNLK = 4, PH_LOCK = 5, PH_EXP = 6;

    typedef struct packed {
        logic        gen_req;
        logic        busy;
        logic        unlock;
        logic        lock;
        logic        expire;
        logic [1:0]  wrng_att;
        logic [15:0] user_otp;
        logic [15:0] otp_ref;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
        string tag;
    } ev_t;

    logic        clk = 1'b0;
    logic        rstn, start, digit_vld, enter, clear, gen_ack;
    logic [3:0]  digit;
    logic [15:0] lfsr_otp;
    logic        gen_req, unlock, lock, expire, busy;
    logic [15:0] otp_ref, user_otp;
    logic [1:0]  wrng_att;

    otp_auth_ctrl #(.EXPIRE_CYC(EXP), .MAX_ATT(MAXA)) dut (
        .clk(clk), .rstn(rstn), .start(start), .digit_vld(digit_vld), .digit(digit),
        .enter(enter), .clear(clear), .gen_req(gen_req), .gen_ack(gen_ack),
        .lfsr_otp(lfsr_otp), .otp_ref(otp_ref), .user_otp(user_otp), .unlock(unlock),
        .lock(lock), .expire(expire), .wrng_att(wrng_att), .busy(busy)
    );

    always #5 clk = ~clk;

    int    edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int    n_chk = 0, n_pass = 0;
    ev_t   sb[$];
    ev_t   probe_q[$];
    string tag = "reset";
    bit    prb = 1'b0;
    snap_t last_exp;
    bit    have_last = 1'b0;

    // Reference model: session phase, entered digits as a list, expiry as an absolute deadline edge.
    int          ph;
    int          digs[$];
    logic [15:0] m_otp;
    int          m_att;
    int          deadline;

    function automatic int digs_value();
        int v = 0;
        foreach (digs[i]) v = v * 16 + digs[i];
        return v;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.gen_req  = (ph == PH_REQ);
        s.busy     = (ph == PH_REQ) || (ph == PH_ENTRY) || (ph == PH_CHECK);
        s.unlock   = (ph == PH_UNLK);
        s.lock     = (ph == PH_LOCK);
        s.expire   = (ph == PH_EXP);
        s.wrng_att = 2'(m_att);
        s.user_otp = 16'(digs_value());
        s.otp_ref  = m_otp;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.gen_req  = gen_req;
        s.busy     = busy;
        s.unlock   = unlock;
        s.lock     = lock;
        s.expire   = expire;
        s.wrng_att = wrng_att;
        s.user_otp = user_otp;
        s.otp_ref  = otp_ref;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("req=%0b busy=%0b unl=%0b lck=%0b exp=%0b att=%0d user=%h ref=%h",
                         s.gen_req, s.busy, s.unlock, s.lock, s.expire, s.wrng_att, s.user_otp, s.otp_ref);
    endfunction

    task automatic model_reset();
        ph = PH_IDLE;
        digs.delete();
        m_otp = '0;
        m_att = 0;
        deadline = 0;
    endtask

    task automatic model_edge(input int e);
        case (ph)
            PH_IDLE: if (start) ph = PH_REQ;
            PH_REQ: if (gen_ack) begin
                m_otp = lfsr_otp;
                digs.delete();
                deadline = e + EXP;
                ph = PH_ENTRY;
            end
            PH_ENTRY: begin
                if (e == deadline) ph = PH_EXP;
                else if (clear) digs.delete();
                else if (enter && digs.size() == 4) ph = PH_CHECK;
                else if (digit_vld && digit <= 4'd9 && digs.size() < 4) digs.push_back(int'(digit));
            end
            PH_CHECK: begin
                if (16'(digs_value()) == m_otp) ph = PH_UNLK;
                else begin
                    m_att++;
                    if (m_att == MAXA) ph = PH_LOCK;
                    else if (e == deadline) ph = PH_EXP;
                    else begin
                        digs.delete();
                        ph = PH_ENTRY;
                    end
                end
            end
            PH_UNLK, PH_EXP: if (start) begin
                m_att = 0;
                ph = PH_REQ;
            end
            default: ;
        endcase
    endtask

    task automatic push_if_changed(input int cyc);
        ev_t   e;
        snap_t s;
        s = model_snap();
        if (!have_last || s !== last_exp) begin
            e.s = s; e.cyc = cyc; e.tag = tag;
            sb.push_back(e);
            last_exp = s;
            have_last = 1'b1;
        end
    endtask

    task automatic check(input string name, input int cyc, input snap_t got, input ev_t e);
        n_chk++;
        if (got === e.s && cyc == e.cyc) n_pass++;
        else $display("FAIL %s: got cyc %0d %s, required cyc %0d %s", name, cyc, fmt(got), e.cyc, fmt(e.s));
    endtask

    snap_t mon_cur, mon_prev;
    bit    mon_first = 1'b1;
    ev_t   mon_ev;

    initial begin : monitor
        forever begin
            @(negedge clk);
            mon_cur = dut_snap();
            if (mon_first || mon_cur !== mon_prev) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_change: got cyc %0d %s, required no change", edge_cnt, fmt(mon_cur));
                end else begin
                    mon_ev = sb.pop_front();
                    check(mon_ev.tag, edge_cnt, mon_cur, mon_ev);
                end
                mon_prev  = mon_cur;
                mon_first = 1'b0;
            end
            while (probe_q.size() > 0 && probe_q[0].cyc <= edge_cnt) begin
                mon_ev = probe_q.pop_front();
                check({"probe_", mon_ev.tag}, edge_cnt, mon_cur, mon_ev);
            end
        end
    end

    task automatic step();
        ev_t p;
        model_edge(edge_cnt + 1);
        push_if_changed(edge_cnt + 1);
        if (prb) begin
            p.s = model_snap(); p.cyc = edge_cnt + 1; p.tag = tag;
            probe_q.push_back(p);
            prb = 1'b0;
        end
        @(negedge clk);
        start = 0; digit_vld = 0; digit = '0; enter = 0; clear = 0; gen_ack = 0;
    endtask

    task automatic go();                   start = 1; step(); endtask
    task automatic ent();                  enter = 1; step(); endtask
    task automatic dig(input int d);       digit_vld = 1; digit = 4'(d); step(); endtask
    task automatic ack(input logic [15:0] v); gen_ack = 1; lfsr_otp = v; step(); endtask
    task automatic idle(input int n);      repeat (n) step(); endtask

    task automatic pulse_reset();
        #2 rstn = 0;
        model_reset();
        push_if_changed(edge_cnt + 1);
        #1;
        n_chk++;
        if (dut_snap() === model_snap()) n_pass++;
        else $display("FAIL async_reset: got %s, required %s", fmt(dut_snap()), fmt(model_snap()));
        @(negedge clk);
        #1 rstn = 1;
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v = '0;
        for (int i = 0; i < 4; i++) v = {v[11:0], 4'($urandom_range(0, 9))};
        return v;
    endfunction

    initial begin : driver
        int          t0;
        int          r;
        int          plan[4];
        bit          good;
        logic [15:0] otp;
        rstn = 1; start = 0; digit_vld = 0; digit = '0; enter = 0; clear = 0;
        gen_ack = 0; lfsr_otp = '0;
        model_reset();
        #1 rstn = 0;
        push_if_changed(edge_cnt + 1);
        @(negedge clk);
        #1 rstn = 1;

        tag = "correct";
        go(); ack(16'h4729);
        dig(4); dig(7); dig(2); dig(9);
        ent(); prb = 1; idle(1);

        tag = "rules";
        go(); ack(16'h5678);
        dig(9); dig(12); prb = 1; dig(3);
        clear = 1; prb = 1; dig(4);
        dig(5); dig(6); dig(7); prb = 1; ent();
        dig(8); prb = 1; dig(1);
        ent(); prb = 1; idle(1);

        tag = "lockout";
        go(); ack(16'h1234);
        repeat (3) begin
            dig(1); dig(2); dig(3); dig(5); ent(); prb = 1; idle(1);
        end
        prb = 1; go(); prb = 1; idle(2);
        pulse_reset();

        tag = "expiry";
        go(); ack(16'h8080); t0 = edge_cnt;
        dig(2); dig(0);
        while (edge_cnt + 1 < t0 + EXP) step();
        prb = 1; step();
        prb = 1; go();

        tag = "exp_vs_enter";
        ack(16'h3141); t0 = edge_cnt;
        dig(3); dig(1); dig(4); dig(1);
        while (edge_cnt + 1 < t0 + EXP) step();
        enter = 1; prb = 1; step();
        prb = 1; idle(1);

        tag = "reset";
        go(); pulse_reset(); prb = 1; idle(1);
        prb = 1; go();
        ack(16'h0000); dig(0); dig(0); dig(0); dig(0); ent(); prb = 1; idle(1);

        tag = "rand";
        for (int s = 0; s < 30; s++) begin
            if (ph == PH_LOCK) pulse_reset();
            go();
            repeat ($urandom_range(0, 3)) begin
                digit_vld = 1; digit = 4'($urandom_range(0, 15)); enter = 1'($urandom_range(0, 1));
                step();
            end
            otp = rand_bcd();
            ack(otp);
            good = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 4; i++)
                plan[i] = good ? int'(otp[15 - 4 * i -: 4]) : int'($urandom_range(0, 9));
            for (int c = 0; c < 300 && (ph == PH_ENTRY || ph == PH_CHECK); c++) begin
                r = int'($urandom_range(0, 99));
                if (r < 55) begin
                    digit_vld = 1;
                    digit = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'(plan[digs.size() % 4]);
                end else if (r < 60) begin
                    clear = 1; digit_vld = 1'($urandom_range(0, 1)); digit = 4'($urandom_range(0, 9));
                end else if (r < 80) begin
                    enter = 1;
                end else if (r < 84) begin
                    start = 1;
                end
                step();
            end
            idle(int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() == 0 && probe_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d events and %0d probes left, required 0 and 0",
                      sb.size(), probe_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500_000;
        n_chk++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
